ahb_controller_arbiter: RTL and testbench

Two-port AHB-Lite manager front end: arbitrates between two simple request/ready requesters (port 0 = instruction fetch, port 1 = data memory) and sequences each granted request into a single non-overlapped AHB-Lite transfer on the `ahb_bus_if.controller_to_mux` modport. It sits between the core's memory stages and the AHB mux.

---
 rtl/ahb_controller_arbiter_if.sv | 22 ++
 rtl/ahb_controller_arbiter.sv | 128 ++++++++++++
 tb/tb_ahb_controller_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_controller_arbiter_if.sv
// AHB-Lite manager bus bundle between the controller/arbiter and the AHB mux.
interface ahb_bus_if;
   logic [31:0] haddr;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport controller_to_mux (
      output haddr, hburst, hsize, htrans, hwdata, hwrite,
      input  hrdata, hready, hresp
   );

   modport mux_to_controller (
      input  haddr, hburst, hsize, htrans, hwdata, hwrite,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_controller_arbiter.sv
// Two-port AHB-Lite manager front end: arbitrates fetch (port 0) and data
// (port 1) requests into single non-overlapped AHB-Lite transfers.
module ahb_controller_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 nrst,
   ahb_bus_if.controller_to_mux ahb,
   input  logic                 m0_req,
   input  logic                 m0_wen,
   input  logic [31:0]          m0_addr,
   input  logic [31:0]          m0_wdata,
   input  logic [1:0]           m0_size,
   output logic [31:0]          m0_rdata,
   output logic                 m0_ready,
   output logic                 m0_err,
   input  logic                 m1_req,
   input  logic                 m1_wen,
   input  logic [31:0]          m1_addr,
   input  logic [31:0]          m1_wdata,
   input  logic [1:0]           m1_size,
   output logic [31:0]          m1_rdata,
   output logic                 m1_ready,
   output logic                 m1_err
);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, MERR} state_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
   } req_t;

   state_t          state;
   logic            prio;
   logic            owner;
   logic [31:0]     wdata_q;

   req_t [1:0]      mreq;
   logic [1:0]      reqv;
   logic            gnt;
   req_t            sel;
   logic            misaligned;

   logic            done;
   logic            err_c;
   logic [31:0]     rdata_c;
   logic [1:0]      rdy;
   logic [1:0]      errv;
   logic [1:0][31:0] rdat;

   assign mreq[0] = {m0_wen, m0_addr, m0_wdata, m0_size};
   assign mreq[1] = {m1_wen, m1_addr, m1_wdata, m1_size};
   assign reqv    = {m1_req, m0_req};

   // Port 1 wins when alone, or on a tie when round-robin points at it.
   always_comb begin
      gnt        = reqv[1] & (~reqv[0] | (RR_EN & prio));
      sel        = mreq[gnt];
      misaligned = (sel.size == 2'd3)
                 | ((sel.size == 2'd1) & sel.addr[0])
                 | ((sel.size == 2'd2) & (|sel.addr[1:0]));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         prio       <= 1'b0;
         owner      <= 1'b0;
         wdata_q    <= '0;
         ahb.htrans <= HTRANS_IDLE;
         ahb.haddr  <= '0;
         ahb.hwdata <= '0;
         ahb.hwrite <= 1'b0;
         ahb.hsize  <= '0;
      end else begin
         case (state)
            IDLE: if (|reqv) begin
               owner   <= gnt;
               wdata_q <= sel.wdata;
               if (RR_EN) prio <= ~gnt;
               if (misaligned) begin
                  state <= MERR;
               end else begin
                  state      <= ADDR;
                  ahb.htrans <= HTRANS_NONSEQ;
                  ahb.haddr  <= sel.addr;
                  ahb.hwrite <= sel.wen;
                  ahb.hsize  <= {1'b0, sel.size};
               end
            end
            ADDR: if (ahb.hready) begin
               state      <= DATA;
               ahb.htrans <= HTRANS_IDLE;
               ahb.hwdata <= wdata_q;
            end
            // hresp with hready low is the first error cycle: just wait.
            DATA: if (ahb.hready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign ahb.hburst = 3'b000;

   always_comb begin
      done    = ((state == DATA) & ahb.hready) | (state == MERR);
      err_c   = (state == MERR) | ahb.hresp;
      rdata_c = (state == DATA) ? ahb.hrdata : '0;
   end

   for (genvar n = 0; n < 2; n++) begin : g_port
      assign rdy[n]  = done & (owner == 1'(n));
      assign errv[n] = rdy[n] & err_c;
      assign rdat[n] = rdy[n] ? rdata_c : '0;
   end

   assign m0_ready = rdy[0];
   assign m0_err   = errv[0];
   assign m0_rdata = rdat[0];
   assign m1_ready = rdy[1];
   assign m1_err   = errv[1];
   assign m1_rdata = rdat[1];
endmodule

// File: tb/tb_ahb_controller_arbiter.sv
// Bench: a round-robin and a fixed-priority instance, each compared every
// cycle against a transaction-level model, plus directed literal checks.
module tb_ahb_controller_arbiter;
   typedef struct packed {
      logic [1:0]  htrans;
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [2:0]  hburst;
      logic [31:0] hwdata;
      logic [1:0]  rdy;
      logic [1:0]  err;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst_v   [2];
   logic        req_v    [2][2];
   logic        wen_v    [2][2];
   logic [31:0] addr_v   [2][2];
   logic [31:0] wdata_v  [2][2];
   logic [1:0]  size_v   [2][2];
   logic        hready_v [2];
   logic        hresp_v  [2];
   logic [31:0] hrdata_v [2];

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
      return (s == 2'd3) || ((a % (32'd1 << s)) != 0);
   endfunction

   function automatic int pick(input bit r0, input bit r1, input bit rr, input bit pr);
      if (r0 && r1) return rr ? int'(pr) : 0;
      return r1 ? 1 : 0;
   endfunction

   for (genvar d = 0; d < 2; d++) begin : g_d
      ahb_bus_if ahbi ();
      obs_t act, exp_o;
      logic r0, r1, e0, e1;
      logic [31:0] rd0, rd1;

      assign ahbi.hready = hready_v[d];
      assign ahbi.hresp  = hresp_v[d];
      assign ahbi.hrdata = hrdata_v[d];

      ahb_controller_arbiter #(.RR_EN(d == 0)) u_dut (
         .clk(clk), .nrst(nrst_v[d]), .ahb(ahbi.controller_to_mux),
         .m0_req(req_v[d][0]), .m0_wen(wen_v[d][0]), .m0_addr(addr_v[d][0]),
         .m0_wdata(wdata_v[d][0]), .m0_size(size_v[d][0]),
         .m0_rdata(rd0), .m0_ready(r0), .m0_err(e0),
         .m1_req(req_v[d][1]), .m1_wen(wen_v[d][1]), .m1_addr(addr_v[d][1]),
         .m1_wdata(wdata_v[d][1]), .m1_size(size_v[d][1]),
         .m1_rdata(rd1), .m1_ready(r1), .m1_err(e1)
      );

      always_comb begin
         act        = '0;
         act.htrans = ahbi.htrans;
         act.haddr  = ahbi.haddr;
         act.hwrite = ahbi.hwrite;
         act.hsize  = ahbi.hsize;
         act.hburst = ahbi.hburst;
         act.hwdata = ahbi.hwdata;
         act.rdy    = {r1, r0};
         act.err    = {e1, e0};
         act.rd0    = rd0;
         act.rd1    = rd1;
      end

      // Model: phase 0 = no transfer, 1 = address phase, 2 = data phase,
      // 3 = misaligned completion; last_* are the bus values last driven.
      int          phase;
      int          win;
      logic        mown, mprio;
      logic [31:0] last_addr, last_wdata, tx_wdata;
      logic        last_wr;
      logic [2:0]  last_size;

      assign win = pick(req_v[d][0], req_v[d][1], d == 0, mprio);

      always @(posedge clk or negedge nrst_v[d]) begin
         if (!nrst_v[d]) begin
            phase <= 0; mown <= 1'b0; mprio <= 1'b0;
            last_addr <= '0; last_wdata <= '0; tx_wdata <= '0;
            last_wr <= 1'b0; last_size <= '0;
         end else begin
            case (phase)
               0: if (req_v[d][0] || req_v[d][1]) begin
                  mown     <= win[0];
                  tx_wdata <= wdata_v[d][win];
                  if (d == 0) mprio <= ~win[0];
                  if (misal(addr_v[d][win], size_v[d][win])) phase <= 3;
                  else begin
                     phase     <= 1;
                     last_addr <= addr_v[d][win];
                     last_wr   <= wen_v[d][win];
                     last_size <= {1'b0, size_v[d][win]};
                  end
               end
               1: if (hready_v[d]) begin phase <= 2; last_wdata <= tx_wdata; end
               2: if (hready_v[d]) phase <= 0;
               default: phase <= 0;
            endcase
         end
      end

      always_comb begin
         exp_o        = '0;
         exp_o.htrans = (phase == 1) ? 2'b10 : 2'b00;
         exp_o.haddr  = last_addr;
         exp_o.hwrite = last_wr;
         exp_o.hsize  = last_size;
         exp_o.hwdata = last_wdata;
         if (phase == 3 || (phase == 2 && hready_v[d])) begin
            exp_o.rdy[mown] = 1'b1;
            exp_o.err[mown] = (phase == 3) || hresp_v[d];
            if (phase == 2) begin
               if (mown) exp_o.rd1 = hrdata_v[d];
               else      exp_o.rd0 = hrdata_v[d];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, a, e, $time);
      end
   endtask

   task automatic cmp_obs(input int d, input obs_t a, input obs_t e);
      chk($sformatf("d%0d htrans", d), 32'(a.htrans), 32'(e.htrans));
      chk($sformatf("d%0d haddr", d),  a.haddr, e.haddr);
      chk($sformatf("d%0d hwrite", d), 32'(a.hwrite), 32'(e.hwrite));
      chk($sformatf("d%0d hsize", d),  32'(a.hsize), 32'(e.hsize));
      chk($sformatf("d%0d hburst", d), 32'(a.hburst), 32'(e.hburst));
      chk($sformatf("d%0d hwdata", d), a.hwdata, e.hwdata);
      chk($sformatf("d%0d ready", d),  32'(a.rdy), 32'(e.rdy));
      chk($sformatf("d%0d err", d),    32'(a.err), 32'(e.err));
      chk($sformatf("d%0d rdata0", d), a.rd0, e.rd0);
      chk($sformatf("d%0d rdata1", d), a.rd1, e.rd1);
   endtask

   always @(negedge clk) if (cmp_en) begin
      cmp_obs(0, g_d[0].act, g_d[0].exp_o);
      cmp_obs(1, g_d[1].act, g_d[1].exp_o);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int d, input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd, input logic [1:0] s);
      req_v[d][p] = r; wen_v[d][p] = w; addr_v[d][p] = a; wdata_v[d][p] = wd; size_v[d][p] = s;
   endtask

   task automatic set_bus(input int d, input logic rdy, input logic resp, input logic [31:0] rd);
      hready_v[d] = rdy; hresp_v[d] = resp; hrdata_v[d] = rd;
   endtask

   task automatic rand_req(input int d, input int p);
      int r;
      logic [1:0] s;
      r = $urandom_range(0, 9);
      s = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      set_req(d, p, 1'b1, 1'($urandom_range(0, 1)), $urandom & 32'h0000_FFFF, $urandom, s);
   endtask

   int          own [2][$];
   int          cyc [2][$];
   logic [1:0]  seen [2];
   int          t2_pat [6] = '{1, 0, 0, 1, 0, 1};

   initial begin
      for (int d = 0; d < 2; d++) begin
         nrst_v[d] = 1'b0;
         set_bus(d, 1'b1, 1'b0, 32'h0);
         for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst htrans", 32'(d == 0 ? g_d[0].act.htrans : g_d[1].act.htrans), 32'd0);
         chk("rst haddr",  d == 0 ? g_d[0].act.haddr  : g_d[1].act.haddr, 32'd0);
         chk("rst hwdata", d == 0 ? g_d[0].act.hwdata : g_d[1].act.hwdata, 32'd0);
         chk("rst ready",  32'(d == 0 ? g_d[0].act.rdy : g_d[1].act.rdy), 32'd0);
      end
      chk("rst hsize", 32'(g_d[0].act.hsize), 32'd0);
      chk("rst hwrite", 32'(g_d[0].act.hwrite), 32'd0);
      tick();
      nrst_v[0] = 1'b1; nrst_v[1] = 1'b1;
      cmp_en = 1'b1;

      // Zero-wait read, port 0
      tick();
      set_req(0, 0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
      set_bus(0, 1'b1, 1'b0, 32'hDEADBEEF);
      tick(); @(negedge clk);
      chk("t1 htrans", 32'(g_d[0].act.htrans), 32'd2);
      chk("t1 haddr", g_d[0].act.haddr, 32'h100);
      chk("t1 hwrite", 32'(g_d[0].act.hwrite), 32'd0);
      chk("t1 model htrans", 32'(g_d[0].exp_o.htrans), 32'd2);
      tick(); @(negedge clk);
      chk("t1 m0_ready", 32'(g_d[0].act.rdy), 32'd1);
      chk("t1 m0_rdata", g_d[0].act.rd0, 32'hDEADBEEF);
      chk("t1 m0_err", 32'(g_d[0].act.err), 32'd0);
      chk("t1 model rdata", g_d[0].exp_o.rd0, 32'hDEADBEEF);
      tick();
      set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);

      // Port 1 write with 2 address-phase and 1 data-phase wait states
      tick();
      set_req(0, 1, 1'b1, 1'b1, 32'h2004, 32'h12345678, 2'd2);
      for (int c = 1; c <= 5; c++) begin
         tick();
         set_bus(0, t2_pat[c][0], 1'b0, 32'h0);
         @(negedge clk);
         if (c <= 3) begin
            chk($sformatf("t2 c%0d htrans", c), 32'(g_d[0].act.htrans), 32'd2);
            chk($sformatf("t2 c%0d haddr", c), g_d[0].act.haddr, 32'h2004);
            chk($sformatf("t2 c%0d hwrite", c), 32'(g_d[0].act.hwrite), 32'd1);
         end else begin
            chk($sformatf("t2 c%0d htrans", c), 32'(g_d[0].act.htrans), 32'd0);
            chk($sformatf("t2 c%0d hwdata", c), g_d[0].act.hwdata, 32'h12345678);
         end
         chk($sformatf("t2 c%0d ready", c), 32'(g_d[0].act.rdy), (c == 5) ? 32'd2 : 32'd0);
      end
      tick();
      set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      set_bus(0, 1'b1, 1'b0, 32'h0);

      // Both ports requesting continuously on both instances
      tick();
      for (int d = 0; d < 2; d++) begin
         set_bus(d, 1'b1, 1'b0, 32'hCAFE0000);
         for (int p = 0; p < 2; p++) set_req(d, p, 1'b1, 1'b0, 32'h40 + 32'(p * 4), 32'h0, 2'd2);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (g_d[0].act.rdy[p]) begin own[0].push_back(p); cyc[0].push_back(c); end
            if (g_d[1].act.rdy[p]) begin own[1].push_back(p); cyc[1].push_back(c); end
         end
         tick();
      end
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("t3 d%0d completions", d), 32'(own[d].size()), 32'd4);
         for (int i = 0; i < own[d].size() && i < 4; i++) begin
            chk($sformatf("t3 d%0d grant%0d", d, i), 32'(own[d][i]), (d == 0) ? 32'(i % 2) : 32'd0);
            chk($sformatf("t3 d%0d cycle%0d", d, i), 32'(cyc[d][i]), 32'(2 + 3 * i));
         end
      end

      // Misaligned word access on port 1
      tick();
      set_req(0, 1, 1'b1, 1'b0, 32'h1002, 32'h0, 2'd2);
      tick(); @(negedge clk);
      chk("t4 htrans", 32'(g_d[0].act.htrans), 32'd0);
      chk("t4 m1_ready", 32'(g_d[0].act.rdy), 32'd2);
      chk("t4 m1_err", 32'(g_d[0].act.err), 32'd2);
      chk("t4 m1_rdata", g_d[0].act.rd1, 32'd0);
      chk("t4 model err", 32'(g_d[0].exp_o.err), 32'd2);
      tick();
      set_req(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      @(negedge clk);
      chk("t4 c2 htrans", 32'(g_d[0].act.htrans), 32'd0);
      chk("t4 c2 ready", 32'(g_d[0].act.rdy), 32'd0);

      // Two-cycle AHB error response
      tick();
      set_req(0, 0, 1'b1, 1'b0, 32'h400, 32'h0, 2'd2);
      tick(); @(negedge clk);
      chk("t5 c1 htrans", 32'(g_d[0].act.htrans), 32'd2);
      tick();
      set_bus(0, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      chk("t5 c2 htrans", 32'(g_d[0].act.htrans), 32'd0);
      chk("t5 c2 ready", 32'(g_d[0].act.rdy), 32'd0);
      chk("t5 c2 err", 32'(g_d[0].act.err), 32'd0);
      tick();
      set_bus(0, 1'b1, 1'b1, 32'h0);
      @(negedge clk);
      chk("t5 c3 htrans", 32'(g_d[0].act.htrans), 32'd0);
      chk("t5 c3 ready", 32'(g_d[0].act.rdy), 32'd1);
      chk("t5 c3 err", 32'(g_d[0].act.err), 32'd1);
      tick();
      set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      set_bus(0, 1'b1, 1'b0, 32'h0);

      // Reset during a data-phase wait
      tick();
      set_req(0, 0, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 2'd2);
      tick();
      tick();
      set_bus(0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t6 hwdata", g_d[0].act.hwdata, 32'hA5A5A5A5);
      #2 nrst_v[0] = 1'b0;
      #1;
      chk("t6 rst htrans", 32'(g_d[0].act.htrans), 32'd0);
      chk("t6 rst haddr", g_d[0].act.haddr, 32'd0);
      chk("t6 rst hwdata", g_d[0].act.hwdata, 32'd0);
      chk("t6 rst hwrite", 32'(g_d[0].act.hwrite), 32'd0);
      chk("t6 rst ready", 32'(g_d[0].act.rdy), 32'd0);
      tick();
      set_bus(0, 1'b1, 1'b0, 32'h0);
      nrst_v[0] = 1'b1;
      tick(); @(negedge clk);
      chk("t6 c1 htrans", 32'(g_d[0].act.htrans), 32'd2);
      chk("t6 c1 haddr", g_d[0].act.haddr, 32'h300);
      tick(); @(negedge clk);
      chk("t6 c2 ready", 32'(g_d[0].act.rdy), 32'd1);
      tick();
      set_req(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);

      // Randomized traffic on both instances
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         seen[0] = g_d[0].act.rdy;
         seen[1] = g_d[1].act.rdy;
         tick();
         for (int d = 0; d < 2; d++) begin
            set_bus(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), $urandom);
            for (int p = 0; p < 2; p++) begin
               if (req_v[d][p]) begin
                  if (seen[d][p]) begin
                     if ($urandom_range(0, 1) == 1) rand_req(d, p);
                     else set_req(d, p, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
                  end
               end else if ($urandom_range(0, 2) == 0) begin
                  rand_req(d, p);
               end
            end
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
